// File: rtl/cla_nibble_sequencer_pkg.sv
// rtl/cla_nibble_sequencer_pkg.sv - shared types and constants for the nibble-serial adder
package cla_nibble_sequencer_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width; a single-nibble adder still needs one counter bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// rtl/cla_nibble_sequencer_if.sv - operand/result handshake bundle for the nibble-serial adder
interface cla_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  import cla_nibble_sequencer_pkg::*;

  localparam int W = NIB_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, busy
  );

endinterface

// File: rtl/cla_nibble_sequencer_cla.sv
// rtl/cla_nibble_sequencer_cla.sv - 4-bit carry-lookahead adder slice
module cla_nibble_sequencer_cla
  import cla_nibble_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from generate/propagate terms, no ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - wide adder that reuses one CLA slice, one nibble per clock
module cla_nibble_sequencer
  import cla_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_nibble_sequencer_if.slave bus
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W-1:0]     sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;
  logic [W-1:0]     sum_next;

  cla_nibble_sequencer_cla u_cla (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The new nibble enters at the top so the LSB nibble ends up at the bottom.
  if (NIBBLES > 1) begin : g_wide
    assign sum_next = {slice_sum, sum_sh[W-1:NIB_W]};
  end else begin : g_single
    assign sum_next = slice_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: accept in IDLE, count nibbles in RUN, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)    state_d = RUN;
      RUN:     if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (bus.out_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one nibble per RUN cycle, latch flags on the last nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            a_msb_q <= bus.a[W-1];
            b_msb_q <= bus.b[W-1];
          end
        end
        RUN: begin
          sum_sh  <= sum_next;
          carry_q <= slice_cout;
          a_sh    <= a_sh >> NIB_W;
          b_sh    <= b_sh >> NIB_W;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= slice_cout;
            zero_q      <= (sum_next == '0);
            ovf_q       <= a_msb_q ^ b_msb_q ^ sum_next[W-1] ^ slice_cout;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sh;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - scoreboard bench for the nibble-serial adder
module tb_cla_nibble_sequencer;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  cla_nibble_sequencer_if #(.NIBBLES(4)) bus ();

  cla_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'b0, c};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (e.sum[15] != a[15]);
    e.zero = (e.sum == 16'h0000);
    return e;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
    end
    sb.push_back(model(a, b, c));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0001;
    bus.b         = 16'h0002;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.sum !== 16'h0000)   begin errors++; $display("FAIL rst_sum got %h exp 0000", bus.sum); end
    checks++; if ({bus.cout, bus.ovf, bus.zero} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b exp 000", {bus.cout, bus.ovf, bus.zero});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_held_valid_accept busy got %b exp 1", bus.busy); end
    sb.push_back(model(16'h0001, 16'h0002, 1'b0));
    bus.in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (!bus.out_valid || sb.size() == 0) begin
      errors++; $display("FAIL rst_held_result out_valid got %b exp 1", bus.out_valid);
    end else begin
      e = sb.pop_front();
      if (bus.sum !== e.sum) begin errors++; $display("FAIL rst_held_sum got %h exp %h", bus.sum, e.sum); end
    end
    take_result();
  endtask

  task automatic test_vectors();
    logic [15:0] va[6] = '{16'h0000, 16'h1234, 16'hAAAA, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] vb[6] = '{16'h0000, 16'h4321, 16'h5555, 16'h0001, 16'h0001, 16'h8000};
    logic        vc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t e;
    int   lat;
    for (int k = 0; k < 6; k++) begin
      send(va[k], vb[k], vc[k]);
      wait_out(lat);
      checks++;
      if (lat != 4 || !bus.out_valid) begin
        errors++; $display("FAIL vec%0d_latency got %0d exp 4 (out_valid=%b)", k, lat, bus.out_valid);
      end
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL vec%0d_scoreboard_empty", k);
      end else begin
        e = sb.pop_front();
        checks++; if (bus.sum !== e.sum)   begin errors++; $display("FAIL vec%0d_sum got %h exp %h", k, bus.sum, e.sum); end
        checks++; if (bus.cout !== e.cout) begin errors++; $display("FAIL vec%0d_cout got %b exp %b", k, bus.cout, e.cout); end
        checks++; if (bus.ovf !== e.ovf)   begin errors++; $display("FAIL vec%0d_ovf got %b exp %b", k, bus.ovf, e.ovf); end
        checks++; if (bus.zero !== e.zero) begin errors++; $display("FAIL vec%0d_zero got %b exp %b", k, bus.zero, e.zero); end
      end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL vec%0d_done_in_ready got %b exp 0", k, bus.in_ready); end
      take_result();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL vec%0d_release out_valid=%b in_ready=%b exp 0/1", k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t e2;
    int   lat;
    send(16'h1234, 16'h1111, 1'b1);
    wait_out(lat);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    bus.a        = 16'h0F0F;
    bus.b        = 16'h00F1;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== e.sum ||
          {bus.cout, bus.ovf, bus.zero} !== {e.cout, e.ovf, e.zero}) begin
        errors++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b sum=%h flags=%b exp 1/0/%h/%b",
                 i, bus.out_valid, bus.in_ready, bus.sum, {bus.cout, bus.ovf, bus.zero},
                 e.sum, {e.cout, e.ovf, e.zero});
      end
      @(negedge clk);
    end
    take_result();
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_early_accept busy=%b in_ready=%b out_valid=%b exp 0/1/0",
                         bus.busy, bus.in_ready, bus.out_valid);
    end
    sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept busy got %b exp 1", bus.busy); end
    wait_out(lat);
    e2 = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== e2.sum || bus.cout !== e2.cout) begin
      errors++; $display("FAIL bp_second_result out_valid=%b sum=%h cout=%b exp 1/%h/%b",
                         bus.out_valid, bus.sum, bus.cout, e2.sum, e2.cout);
    end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat;
    logic seen;
    send(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b exp 0", seen); end
    send(16'h00FF, 16'h0001, 1'b0);
    wait_out(lat);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0100 || bus.sum !== e.sum) begin
      errors++; $display("FAIL midrst_after_sum got %h (valid %b) exp 0100", bus.sum, bus.out_valid);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   accepted;
    int   done;
    int   cycles;
    int   last_acc;
    logic pending;
    accepted      = 0;
    done          = 0;
    cycles        = 0;
    last_acc      = -1;
    bus.out_ready = 1'b1;
    bus.a         = 16'($urandom);
    bus.b         = 16'($urandom);
    bus.cin       = 1'($urandom);
    bus.in_valid  = 1'b1;
    while (done < 1000 && cycles < 7000) begin
      pending = 1'b0;
      if (bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_result sum=%h", bus.sum);
        end else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf, bus.zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            errors++; $display("FAIL b2b_result%0d got %h/%b%b%b exp %h/%b%b%b", done,
                               bus.sum, bus.cout, bus.ovf, bus.zero, e.sum, e.cout, e.ovf, e.zero);
          end
        end
        done++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b, bus.cin));
        if (last_acc >= 0) begin
          checks++;
          if (cycles - last_acc != 6) begin
            errors++; $display("FAIL b2b_interval got %0d exp 6", cycles - last_acc);
          end
        end
        last_acc = cycles;
        accepted++;
        pending  = 1'b1;
      end
      @(negedge clk);
      cycles++;
      if (pending) begin
        if (accepted >= 1000) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.a   = 16'($urandom);
          bus.b   = 16'($urandom);
          bus.cin = 1'($urandom);
        end
      end
    end
    checks++;
    if (done != 1000) begin
      errors++; $display("FAIL b2b_count got %0d exp 1000", done);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
